// File: rtl/xs3_pkg.sv
// rtl/xs3_pkg.sv - shared types and constants for the sequential BCD to Excess-3 converter
package xs3_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] XS3_OFFSET = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xs3_digit.sv
// rtl/xs3_digit.sv - stateless single-digit BCD to Excess-3 converter with invalid-digit flag
module xs3_digit
  import xs3_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [DIGIT_W-1:0] xs3,
  output logic               invalid
);

  // Wraps modulo 16, so codes 10..15 still produce a defined nibble.
  assign xs3     = bcd + XS3_OFFSET;
  assign invalid = (bcd > 4'd9);

endmodule

// File: rtl/bcd_xs3_seq.sv
// rtl/bcd_xs3_seq.sv - multi-digit BCD to Excess-3 converter, one digit per cycle, LSD first
// Optional invalid-digit abort enabled by defining XS3_ERR_CHECK_EN.
module bcd_xs3_seq
  import xs3_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIGIT_W*NDIG-1:0] bcd_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DIGIT_W*NDIG-1:0] xs3_out,
  output logic                  err
);

  localparam int W     = DIGIT_W * NDIG;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

`ifdef XS3_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       operand;
  logic [W-1:0]       work;
  logic [W-1:0]       work_nxt;
  logic [W-1:0]       xs3_q;
  logic [IDX_W-1:0]   idx;
  logic               err_q;
  logic [DIGIT_W-1:0] dig_bcd;
  logic [DIGIT_W-1:0] dig_xs3;
  logic               dig_invalid;
  logic               abort;
  logic               last;

  assign dig_bcd = operand[DIGIT_W*int'(idx) +: DIGIT_W];

  xs3_digit u_digit (
    .bcd     (dig_bcd),
    .xs3     (dig_xs3),
    .invalid (dig_invalid)
  );

  assign last  = (idx == LAST_IDX);
  assign abort = ERR_EN && dig_invalid;

  always_comb begin
    work_nxt = work;
    work_nxt[DIGIT_W*int'(idx) +: DIGIT_W] = dig_xs3;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (abort || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The final nibble goes straight into xs3_q so the result is visible on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      operand <= '0;
      work    <= '0;
      xs3_q   <= '0;
      idx     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            operand <= bcd_in;
            idx     <= '0;
            err_q   <= 1'b0;
          end
        end
        CONV: begin
          if (abort) begin
            err_q <= 1'b1;
          end else begin
            work <= work_nxt;
            if (last) xs3_q <= work_nxt;
            else      idx   <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready   = (state == IDLE);
  assign busy    = (state == CONV);
  assign done    = (state == DONE);
  assign xs3_out = xs3_q;
  assign err     = ERR_EN & err_q;

endmodule
